// File: rtl/bcd_arb_pkg.sv
// Shared definitions for the BCD converter arbiter: state encodings, data widths
// and the requester-id width helper.
package bcd_arb_pkg;

    localparam int unsigned BIN_W = 32;
    localparam int unsigned BCD_W = 40;

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_ISSUE  = 2'b01;
    localparam logic [1:0] S_WAIT   = 2'b10;
    localparam logic [1:0] S_RETURN = 2'b11;

    function automatic int unsigned id_width(input int unsigned n);
        return (n < 2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/bcd_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request searching upward
// from last_i+1 with wrap-around.
module rr_picker
    import bcd_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]              req_i,
    input  logic [id_width(N_REQ)-1:0]    last_i,
    output logic [N_REQ-1:0]              gnt_o,
    output logic [id_width(N_REQ)-1:0]    gnt_id_o,
    output logic                          any_o
);

    localparam int unsigned IDW = id_width(N_REQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);

    logic [IDW-1:0] idx;

    always_comb begin
        gnt_o    = '0;
        gnt_id_o = '0;
        any_o    = 1'b0;
        idx      = last_i;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (idx == LAST_ID) ? '0 : idx + IDW'(1);
            if (!any_o && req_i[idx]) begin
                any_o      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_id_o   = idx;
            end
        end
    end

endmodule

// File: rtl/bcd_arbiter.sv
// Round-robin sequencer sharing one binary-to-BCD converter among N_REQ requesters.
// Optional WAIT timeout with error response: define BCD_ARB_TIMEOUT_EN.
module bcd_arbiter
    import bcd_arb_pkg::*;
#(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [BIN_W*N_REQ-1:0]        req_data_i,
    input  logic [N_REQ-1:0]              req_valid_i,
    output logic [N_REQ-1:0]              req_ready_o,
    output logic [BCD_W-1:0]              rsp_data_o,
    output logic                          rsp_err_o,
    output logic [id_width(N_REQ)-1:0]    rsp_id_o,
    output logic [N_REQ-1:0]              rsp_valid_o,
    input  logic [N_REQ-1:0]              rsp_ready_i,
    output logic [BIN_W-1:0]              conv_bin_data_o,
    output logic                          conv_bin_valid_o,
    input  logic                          conv_bin_ready_i,
    input  logic [BCD_W-1:0]              conv_bcd_data_i,
    input  logic                          conv_bcd_valid_i,
    output logic                          conv_bcd_ready_o
);

    localparam int unsigned IDW = id_width(N_REQ);

    logic [1:0]       state_q, state_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [BIN_W-1:0] op_q, op_d;
    logic [BCD_W-1:0] res_q, res_d;

    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gnt_id;
    logic             any_valid;
    logic             in_ret;

`ifdef BCD_ARB_TIMEOUT_EN
    logic             err_q, err_d;
    logic [15:0]      cnt_q, cnt_d;
`endif

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req_i    (req_valid_i),
        .last_i   (last_q),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id),
        .any_o    (any_valid)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        op_d    = op_q;
        res_d   = res_q;
`ifdef BCD_ARB_TIMEOUT_EN
        err_d   = err_q;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                // The picker only grants asserted requests, so any_valid is the accept handshake.
                if (any_valid) begin
                    id_d = gnt_id;
                    for (int unsigned k = 0; k < N_REQ; k++) begin
                        if (gnt[k]) op_d = req_data_i[k*BIN_W +: BIN_W];
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (conv_bin_ready_i) begin
                    state_d = S_WAIT;
`ifdef BCD_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_WAIT: begin
                if (conv_bcd_valid_i) begin
                    res_d   = conv_bcd_data_i;
                    state_d = S_RETURN;
`ifdef BCD_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_RETURN;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
`endif
                end
            end
            S_RETURN: begin
                if (rsp_ready_i[id_q]) begin
                    last_d  = id_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            last_q  <= IDW'(N_REQ - 1);
            id_q    <= '0;
            op_q    <= '0;
            res_q   <= '0;
`ifdef BCD_ARB_TIMEOUT_EN
            err_q   <= 1'b0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            op_q    <= op_d;
            res_q   <= res_d;
`ifdef BCD_ARB_TIMEOUT_EN
            err_q   <= err_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Outputs are decoded from state so everything reads 0 outside its own phase.
    assign in_ret           = (state_q == S_RETURN);
    assign req_ready_o      = (state_q == S_IDLE) ? gnt : '0;
    assign conv_bin_valid_o = (state_q == S_ISSUE);
    assign conv_bin_data_o  = conv_bin_valid_o ? op_q : '0;
    assign conv_bcd_ready_o = (state_q == S_WAIT);
    assign rsp_valid_o      = in_ret ? ({{(N_REQ-1){1'b0}}, 1'b1} << id_q) : '0;
    assign rsp_id_o         = in_ret ? id_q : '0;
    assign rsp_data_o       = in_ret ? res_q : '0;
`ifdef BCD_ARB_TIMEOUT_EN
    assign rsp_err_o        = in_ret & err_q;
`else
    assign rsp_err_o        = 1'b0;
`endif

endmodule
